divider_unit: RTL and testbench
===============================

# divider_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, located in the execute stage. It produces the execute-stage stall request that the pipeline controller consumes: while a division is in flight, decode and fetch are frozen. When the pipeline controller raises an execute-stage stall because of a memory-stage stall, the unit holds its finished result.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-low.
- `en_i` input 1: a divide instruction is present in the execute stage. Held high by the upstream register for as long as that stage is stalled.
- `op_i` input 2: operation select.
  - 2'b00 DIV
  - 2'b01 DIVU
  - 2'b10 REM
  - 2'b11 REMU
- `operand1_i` input 32: dividend.
- `operand2_i` input 32: divisor.
- `stall_execute_stage_i` input 1: execute stage frozen by a downstream (memory) stall.
- `result_o` output 32: quotient or remainder.
- `result_valid_o` output 1: `result_o` is valid this cycle.
- `en_stall_execute_stage_o` output 1: execute-stage stall request to the pipeline controller.

## Operation
- FSM states: IDLE, BUSY, FIX, DONE.
- **IDLE**
  - On `en_i`=1, latch the operation and the operands.
  - For DIV/REM, latch the absolute values of both operands, plus the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
  - Clear the 6-bit iteration counter, load the quotient register with |dividend|, clear the 33-bit partial remainder, then go to BUSY.
- **BUSY** (one iteration per cycle, 32 cycles)
  - Shift {rem, quot} left by 1.
  - Compute trial = rem[32:0] − {1'b0, divisor}.
  - If trial is non-negative: rem = trial and quot[0] = 1; otherwise quot[0] = 0.
  - After counter reaches 31, go to FIX.
- **FIX**
  - Negate the quotient if its sign is set, and negate the remainder if its sign is set (signed ops only).
  - Select quotient or remainder per `op_i`, register it into `result_o`, then go to DONE.
- **DONE**
  - `result_valid_o`=1.
  - If `stall_execute_stage_i`=1, stay in DONE and hold `result_o`. Otherwise go to IDLE.
  - `en_i` seen in DONE belongs to the completing instruction and must not be re-accepted.
- Stall request: `en_stall_execute_stage_o` = (IDLE & `en_i`) | BUSY | FIX. It is combinational, so the request is raised in the same cycle the instruction arrives.
- Divide by zero (RISC-V semantics):
  - quotient = 0xFFFFFFFF for both DIV and DIVU.
  - remainder = dividend.
  - Signed correction must not alter these values.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Reset values: state = IDLE, `result_o` = 0, `result_valid_o` = 0, `en_stall_execute_stage_o` = 0 (forced low while `rst_i` = 0).
- Reset mid-operation: abort, discard partial results, return to IDLE on the next edge.

## Timing
- Accept at cycle 0 → BUSY on cycles 1–32 → FIX on cycle 33 → DONE on cycle 34. Latency is 34 cycles from the accept cycle to `result_valid_o`.
- `en_stall_execute_stage_o` is high on cycles 0–33 and low on cycle 34, so the pipeline advances at the end of cycle 34.
- Back-to-back divides: the next `en_i` is accepted in the IDLE cycle that follows DONE (minimum spacing of 35 cycles).
- `stall_execute_stage_i` is ignored in IDLE, BUSY and FIX; iteration continues regardless.
- `op_i` and the operands are sampled only in the accept cycle; later changes have no effect.

## Configuration
- `DIVIDER_SPECIAL_CASE_EN` defined:
  - A zero divisor or signed overflow is detected in the accept cycle.
  - The special result is written directly and the FSM goes IDLE → DONE, giving a latency of 1 cycle.
  - `en_stall_execute_stage_o` is high only in cycle 0.
- Not defined:
  - Special cases run the full 34-cycle path.
  - FIX overrides the result with the same special values.

## Test plan
- **DIV, signed with remainder:** op 00, 0xFFFFFFF9 (−7) / 2.
  - `result_o` = 0xFFFFFFFD at cycle 34, `result_valid_o` = 1.
  - Stall high on cycles 0–33.
  - Same operands with REM → 0xFFFFFFFF.
- **Divide by zero:** DIVU 100 / 0 → 0xFFFFFFFF; REM 0xFFFFFFF9 / 0 → 0xFFFFFFF9.
  - Latency 34 cycles without the macro, 1 cycle with it.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- **Held result under downstream stall:** REMU 1000 / 7.
  - Hold `stall_execute_stage_i` = 1 for 5 cycles in DONE.
  - `result_o` = 6 and `result_valid_o` = 1 throughout, with no re-accept of the held `en_i`.
- **Back-to-back and reset:**
  - Two DIVU ops issued back-to-back: 0xFFFFFFFF / 3 → 0x55555555, then 10 / 3 → 3.
  - Then a new op with `rst_i` = 0 at cycle 10: outputs return to 0, state IDLE, no `result_valid_o`.

Source files
------------

// File: rtl/divider_unit_if.sv
// Execute-stage divider request/response bundle.
// slave: the divider; master: the execute-stage driver.
interface divider_unit_if;
    logic        en_i;
    logic [1:0]  op_i;
    logic [31:0] operand1_i;
    logic [31:0] operand2_i;
    logic        stall_execute_stage_i;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        en_stall_execute_stage_o;

    modport slave (
        input  en_i,
        input  op_i,
        input  operand1_i,
        input  operand2_i,
        input  stall_execute_stage_i,
        output result_o,
        output result_valid_o,
        output en_stall_execute_stage_o
    );

    modport master (
        output en_i,
        output op_i,
        output operand1_i,
        output operand2_i,
        output stall_execute_stage_i,
        input  result_o,
        input  result_valid_o,
        input  en_stall_execute_stage_o
    );
endinterface

// File: rtl/divider_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Optional DIVIDER_SPECIAL_CASE_EN: zero divisor / signed overflow finish in 1 cycle.
module divider_unit (
    input  logic          clk_i,
    input  logic          rst_i,
    divider_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] dividend_q, dividend_d;
    logic [1:0]  op_q, op_d;
    logic        qsign_q, qsign_d;
    logic        rsign_q, rsign_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;
    logic [31:0] result_q, result_d;

    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic        div0_in, ovf_in, special_in;
    logic [31:0] special_res;
    logic [33:0] shift_rem;
    logic [33:0] trial;
    logic [31:0] q_fix, r_fix, fix_res;

    // Accept-cycle operand conditioning and special-case detection
    always_comb begin
        signed_op = ~bus.op_i[0];
        a_neg     = signed_op & bus.operand1_i[31];
        b_neg     = signed_op & bus.operand2_i[31];
        a_abs     = a_neg ? (32'd0 - bus.operand1_i) : bus.operand1_i;
        b_abs     = b_neg ? (32'd0 - bus.operand2_i) : bus.operand2_i;
        div0_in   = (bus.operand2_i == 32'd0);
        ovf_in    = signed_op & (bus.operand1_i == 32'h8000_0000)
                    & (bus.operand2_i == 32'hFFFF_FFFF);
`ifdef DIVIDER_SPECIAL_CASE_EN
        special_in = div0_in | ovf_in;
`else
        special_in = 1'b0;
`endif
        if (div0_in) begin
            special_res = bus.op_i[1] ? bus.operand1_i : 32'hFFFF_FFFF;
        end else begin
            special_res = bus.op_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring-division step: shift {rem, quot} and trial-subtract
    always_comb begin
        shift_rem = {rem_q, quot_q[31]};
        trial     = shift_rem - {2'b00, divisor_q};
    end

    // Sign correction, then force the architected special-case values
    always_comb begin
        q_fix = qsign_q ? (32'd0 - quot_q) : quot_q;
        r_fix = rsign_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
        if (div0_q) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = dividend_q;
        end else if (ovf_q) begin
            q_fix = 32'h8000_0000;
            r_fix = 32'd0;
        end
        fix_res = op_q[1] ? r_fix : q_fix;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    state_d = special_in ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (!bus.stall_execute_stage_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the stall request is combinational and masked by reset
    always_comb begin
        bus.result_valid_o = (state_q == DONE);
        bus.en_stall_execute_stage_o = rst_i & (
            ((state_q == IDLE) & bus.en_i) |
            (state_q == BUSY) |
            (state_q == FIX));
        bus.result_o = result_q;
    end

    // Datapath next-state: latch on accept, iterate in BUSY, finalise in FIX
    always_comb begin
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        op_d       = op_q;
        qsign_d    = qsign_q;
        rsign_d    = rsign_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    op_d       = bus.op_i;
                    divisor_d  = b_abs;
                    dividend_d = bus.operand1_i;
                    quot_d     = a_abs;
                    rem_d      = 33'd0;
                    cnt_d      = 6'd0;
                    qsign_d    = a_neg ^ b_neg;
                    rsign_d    = a_neg;
                    div0_d     = div0_in;
                    ovf_d      = ovf_in;
                    if (special_in) begin
                        result_d = special_res;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 6'd1;
                if (!trial[33]) begin
                    rem_d  = trial[32:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = shift_rem[32:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
            end
            FIX: begin
                result_d = fix_res;
            end
            DONE: begin
                result_d = result_q;
            end
            default: begin
                result_d = result_q;
            end
        endcase
    end

    // Datapath registers; reset discards any in-flight division
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q      <= 6'd0;
            quot_q     <= 32'd0;
            rem_q      <= 33'd0;
            divisor_q  <= 32'd0;
            dividend_q <= 32'd0;
            op_q       <= 2'b00;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            op_q       <= op_d;
            qsign_q    <= qsign_d;
            rsign_q    <= rsign_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit.
// Expected results come from a behavioural RV32M model via a scoreboard queue.
module tb_divider_unit;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    logic [31:0] exp_q[$];

    divider_unit_if bus ();

    divider_unit dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (b == 32'd0) ||
                  (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIVIDER_SPECIAL_CASE_EN
        return special ? 1 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Issue one op, hold en_i, scramble inputs after accept, wait for valid.
    // Returns at the negedge of the DONE cycle with en_i still high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int stall_cnt, output logic [31:0] res);
        @(negedge clk);
        bus.en_i       = 1'b1;
        bus.op_i       = op;
        bus.operand1_i = a;
        bus.operand2_i = b;
        exp_q.push_back(ref_div(op, a, b));
        lat       = -1;
        stall_cnt = 0;
        res       = 32'd0;
        #1;
        if (bus.en_stall_execute_stage_o) stall_cnt++;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.en_stall_execute_stage_o) stall_cnt++;
            if (bus.result_valid_o) begin
                lat = n;
                res = bus.result_o;
                break;
            end
            bus.op_i       = ~op;
            bus.operand1_i = $urandom;
            bus.operand2_i = $urandom;
        end
    endtask

    task automatic retire();
        bus.en_i = 1'b0;
        bus.stall_execute_stage_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.en_i = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (bus.result_o !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_result: got %h exp 0", bus.result_o);
        end
        compared++;
        if (bus.result_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid: got %b exp 0", bus.result_valid_o);
        end
        compared++;
        if (bus.en_stall_execute_stage_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_stall: got %b exp 0",
                     bus.en_stall_execute_stage_o);
        end
        bus.en_i = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_div_signed();
        int lat, sc;
        logic [31:0] res, e;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat, sc, res);
        e = exp_q.pop_front();
        compared++;
        if (res !== e) begin
            mismatched++;
            $display("FAIL div_signed: got %h exp %h", res, e);
        end
        compared++;
        if (lat != 34) begin
            mismatched++;
            $display("FAIL div_latency: got %0d exp 34", lat);
        end
        compared++;
        if (sc != 34) begin
            mismatched++;
            $display("FAIL div_stall_cycles: got %0d exp 34", sc);
        end
        retire();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, sc, res);
        e = exp_q.pop_front();
        compared++;
        if (res !== e) begin
            mismatched++;
            $display("FAIL rem_signed: got %h exp %h", res, e);
        end
        retire();
    endtask

    task automatic test_div_zero();
        int lat, sc, el;
        logic [31:0] res, e;
        logic [1:0]  ops[3];
        logic [31:0] as[3];
        ops[0] = 2'b01; as[0] = 32'd100;
        ops[1] = 2'b10; as[1] = 32'hFFFF_FFF9;
        ops[2] = 2'b00; as[2] = 32'hFFFF_FFF9;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], 32'd0, lat, sc, res);
            e  = exp_q.pop_front();
            el = exp_lat(ops[i], as[i], 32'd0);
            compared++;
            if (res !== e) begin
                mismatched++;
                $display("FAIL div_zero_%0d: got %h exp %h", i, res, e);
            end
            compared++;
            if (lat != el || sc != el) begin
                mismatched++;
                $display("FAIL div_zero_lat_%0d: got %0d/%0d exp %0d",
                         i, lat, sc, el);
            end
            retire();
        end
    endtask

    task automatic test_overflow();
        int lat, sc, el;
        logic [31:0] res, e;
        for (int i = 0; i < 2; i++) begin
            run_op(i == 0 ? 2'b00 : 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                   lat, sc, res);
            e  = exp_q.pop_front();
            el = exp_lat(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
            compared++;
            if (res !== e) begin
                mismatched++;
                $display("FAIL overflow_%0d: got %h exp %h", i, res, e);
            end
            compared++;
            if (lat != el) begin
                mismatched++;
                $display("FAIL overflow_lat_%0d: got %0d exp %0d", i, lat, el);
            end
            retire();
        end
    endtask

    task automatic test_held_stall();
        int lat, sc;
        logic [31:0] res, e;
        run_op(2'b11, 32'd1000, 32'd7, lat, sc, res);
        e = exp_q.pop_front();
        compared++;
        if (res !== e) begin
            mismatched++;
            $display("FAIL held_result: got %h exp %h", res, e);
        end
        bus.stall_execute_stage_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (bus.result_valid_o !== 1'b1 || bus.result_o !== e ||
                bus.en_stall_execute_stage_o !== 1'b0) begin
                mismatched++;
                $display("FAIL held_%0d: got v=%b r=%h s=%b exp v=1 r=%h s=0",
                         i, bus.result_valid_o, bus.result_o,
                         bus.en_stall_execute_stage_o, e);
            end
        end
        retire();
        @(negedge clk);
        compared++;
        if (bus.result_valid_o !== 1'b0 ||
            bus.en_stall_execute_stage_o !== 1'b0) begin
            mismatched++;
            $display("FAIL held_release: got v=%b s=%b exp v=0 s=0",
                     bus.result_valid_o, bus.en_stall_execute_stage_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat, sc;
        logic [31:0] res, e;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd3, lat, sc, res);
        retire();
        e = exp_q.pop_front();
        compared++;
        if (res !== e) begin
            mismatched++;
            $display("FAIL b2b_first: got %h exp %h", res, e);
        end
        run_op(2'b01, 32'd10, 32'd3, lat, sc, res);
        retire();
        e = exp_q.pop_front();
        compared++;
        if (res !== e || lat != 34) begin
            mismatched++;
            $display("FAIL b2b_second: got %h lat %0d exp %h lat 34",
                     res, lat, e);
        end
    endtask

    task automatic test_reset_mid();
        int lat, sc;
        logic [31:0] res, e;
        @(negedge clk);
        bus.en_i       = 1'b1;
        bus.op_i       = 2'b11;
        bus.operand1_i = 32'd1000;
        bus.operand2_i = 32'd7;
        repeat (10) @(negedge clk);
        compared++;
        if (bus.result_o !== 32'd3 || bus.en_stall_execute_stage_o !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_before: got r=%h s=%b exp r=3 s=1",
                     bus.result_o, bus.en_stall_execute_stage_o);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.en_stall_execute_stage_o !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_stall_forced: got %b exp 0",
                     bus.en_stall_execute_stage_o);
        end
        bus.en_i = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.result_o !== 32'd0 || bus.result_valid_o !== 1'b0 ||
            bus.en_stall_execute_stage_o !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: got r=%h v=%b s=%b exp 0/0/0",
                     bus.result_o, bus.result_valid_o,
                     bus.en_stall_execute_stage_o);
        end
        rst_n = 1'b1;
        run_op(2'b01, 32'd77, 32'd5, lat, sc, res);
        retire();
        e = exp_q.pop_front();
        compared++;
        if (res !== e || lat != 34) begin
            mismatched++;
            $display("FAIL mid_after: got %h lat %0d exp %h lat 34",
                     res, lat, e);
        end
    endtask

    task automatic test_random();
        int lat, sc, el;
        logic [31:0] res, e, a, b;
        logic [1:0]  op;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 100))
                                             : $urandom;
            if (i == 7) b = 32'd0;
            el = exp_lat(op, a, b);
            run_op(op, a, b, lat, sc, res);
            retire();
            e = exp_q.pop_front();
            compared++;
            if (res !== e || lat != el) begin
                mismatched++;
                $display("FAIL random_%0d op%0d %h/%h: got %h lat %0d exp %h lat %0d",
                         i, op, a, b, res, lat, e, el);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.en_i   = 1'b0;
        bus.op_i   = 2'b00;
        bus.operand1_i = 32'd0;
        bus.operand2_i = 32'd0;
        bus.stall_execute_stage_i = 1'b0;
        test_reset();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_held_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
